aes_key_expand: RTL and testbench

Iterative AES-128 key expansion unit feeding the AES encryption core. It captures a 128-bit cipher key on `start` and computes the 11 FIPS-197 round keys, one per clock, using RotWord, SubWord (a full S-box) and Rcon. It holds all 11 keys in an internal register file. The core's round datapath reads any key combinationally by round index once `keys_valid` is high.

---
 rtl/aes_key_expand.sv | 134 +++++++++++++
 tb/tb_aes_key_expand.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: captures a cipher key on start, then derives the
// ten following round keys one per clock into an 11-entry register file.
// Any stored key is read combinationally by round index.
`timescale 1ns/1ps
module aes_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         keys_valid,
  output logic         done
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t         state_reg, state_next;
  logic [3:0]     cnt_reg;
  logic [7:0]     rcon_reg;
  logic           keys_valid_reg;
  logic           done_reg;
  logic [127:0]   rk [0:10];

  logic           start_accept;
  logic           expanding;
  logic           last_step;
  logic [3:0]     prev_idx;
  logic [127:0]   prev_key;
  logic [31:0]    rot_word;
  logic [31:0]    sub_word;
  logic [31:0]    t_word;
  logic [31:0]    n_w0, n_w1, n_w2, n_w3;
  logic [127:0]   next_key;

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state: start only matters in IDLE, EXPAND ends once rk[10] is written.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (cnt_reg == 4'd10) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM-derived controls.
  always_comb begin
    busy         = (state_reg == EXPAND);
    start_accept = (state_reg == IDLE) && start;
    expanding    = (state_reg == EXPAND);
    last_step    = (state_reg == EXPAND) && (cnt_reg == 4'd10);
  end

  // Previous round key; cnt is 1..10 while expanding, other values are unused.
  always_comb begin
    prev_idx = cnt_reg - 4'd1;
    prev_key = (prev_idx <= 4'd10) ? rk[prev_idx] : '0;
  end

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  // Four parallel S-box lookups form SubWord within one cycle.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_word[8*gi +: 8] = SBOX[rot_word[8*gi +: 8]];
    end
  endgenerate

  assign t_word   = sub_word ^ {rcon_reg, 24'h0};
  assign n_w0     = prev_key[127:96] ^ t_word;
  assign n_w1     = prev_key[95:64]  ^ n_w0;
  assign n_w2     = prev_key[63:32]  ^ n_w1;
  assign n_w3     = prev_key[31:0]   ^ n_w2;
  assign next_key = {n_w0, n_w1, n_w2, n_w3};

  // Register file, round counter, Rcon and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) rk[i] <= '0;
      cnt_reg        <= 4'd0;
      rcon_reg       <= 8'h01;
      keys_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= last_step;
      if (start_accept) begin
        rk[0]          <= key;
        rcon_reg       <= 8'h01;
        cnt_reg        <= 4'd1;
        keys_valid_reg <= 1'b0;
      end else if (expanding) begin
        rk[cnt_reg] <= next_key;
        rcon_reg    <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
        if (last_step) keys_valid_reg <= 1'b1;
        else           cnt_reg        <= cnt_reg + 4'd1;
      end
    end
  end

  // Zero-latency read port; indices beyond the last round read as zero.
  always_comb begin
    round_key = (round_sel <= 4'd10) ? rk[round_sel] : '0;
  end

  assign keys_valid = keys_valid_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomised scoreboard bench for aes_key_expand with a FIPS-197 word-array
// reference model and an S-box derived from GF(2^8) inversion.
`timescale 1ns/1ps
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [3:0]   round_sel = '0;
  logic [127:0] round_key;
  logic         busy, keys_valid, done;

  aes_key_expand dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key),
    .round_sel(round_sel), .round_key(round_key),
    .busy(busy), .keys_valid(keys_valid), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct {
    logic [127:0] rk [11];
    int           done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  logic [7:0]  sbox_ref [256];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  // FIPS-197 KeyExpansion over 44 words.
  function automatic exp_t make_exp(input logic [127:0] k, input int dc);
    exp_t        e;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) e.rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    e.done_cyc = dc;
    return e;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: on every done pulse pop the oldest expectation and sweep all indices.
  initial begin
    logic kv_prev;
    exp_t e;
    kv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        check("kv_low_before_done", kv_prev, 1'b0);
        check("kv_at_done", keys_valid, 1'b1);
        check("busy_at_done", busy, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: actual done=1 at cycle %0d required no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          for (int i = 0; i < 16; i++) begin
            round_sel = 4'(i);
            #0.1;
            if (i <= 10) check($sformatf("rk%0d", i), round_key, e.rk[i]);
            else         check($sformatf("rk%0d_zero", i), round_key, '0);
          end
        end
      end
      kv_prev = keys_valid;
    end
  end

  task automatic issue_start(input logic [127:0] k, input bit push);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    if (push) exp_q.push_back(make_exp(k, cyc + 11));
    @(negedge clk);
    start = 1'b0;
    key   = rand128();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!(keys_valid === 1'b1 && busy === 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("keys_valid_in_time", keys_valid, 1'b1);
    #3;
  endtask

  task automatic chk_rk(input string name, input int sel, input logic [127:0] req);
    round_sel = 4'(sel);
    #0.1;
    check(name, round_key, req);
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < 16; i++) chk_rk($sformatf("%s_rk%0d", name, i), i, '0);
  endtask

  // Stimulus
  initial begin
    logic [127:0] k;
    int kv_cnt, done_cnt, n;
    build_sbox();
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_kv", keys_valid, 1'b0);
    check("reset_done", done, 1'b0);
    sweep_zero("reset");
    rst_n = 1'b1;

    // FIPS-197 A.1
    issue_start(KEY_A1, 1'b1);
    wait_valid();
    chk_rk("a1_rk0", 0, KEY_A1);
    chk_rk("a1_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    chk_rk("a1_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // All-zero key restarting from the completed state
    issue_start('0, 1'b1);
    check("kv_drop_on_restart", keys_valid, 1'b0);
    check("busy_on_restart", busy, 1'b1);
    wait_valid();
    chk_rk("zero_rk1", 1, 128'h62636363626363636263636362636363);
    chk_rk("zero_rk10", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk_rk("zero_sel11", 11, '0);
    chk_rk("zero_sel15", 15, '0);

    // Starts during an expansion are ignored
    issue_start(rand128(), 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; key = rand128();
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; key = rand128();
    @(negedge clk);
    start = 1'b0;
    wait_valid();

    // Asynchronous reset in the middle of an expansion
    issue_start(rand128(), 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_kv", keys_valid, 1'b0);
    check("midrst_done", done, 1'b0);
    sweep_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    issue_start(KEY_A1, 1'b1);
    wait_valid();
    chk_rk("post_rst_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // start held high: acceptance every 11th edge, random key each cycle
    kv_cnt = 0;
    done_cnt = 0;
    for (int j = 0; j < 33; j++) begin
      @(negedge clk);
      if (j >= 1 && keys_valid === 1'b1) kv_cnt++;
      if (j >= 1 && done === 1'b1) done_cnt++;
      start = 1'b1;
      key   = rand128();
      if (j % 11 == 0) exp_q.push_back(make_exp(key, cyc + 11));
    end
    @(negedge clk);
    start = 1'b0;
    check("hold_kv_cycles", kv_cnt, 2);
    check("hold_done_pulses", done_cnt, 2);
    wait_valid();

    // Random keys back to back
    for (int j = 0; j < 16; j++) begin
      k = rand128();
      issue_start(k, 1'b1);
      wait_valid();
    end

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout at %0t required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
